// File: rtl/tia_phase_gen.sv
// Two-phase non-overlapping strobe generator for the TIA dynamic shift-register
// clocking (s1/s2). Each phase cycle is DIV clocks: s1, gap, s2, gap.
module tia_phase_gen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    input  logic sync,
    output logic s1,
    output logic s2,
    output logic busy,
    output logic cycle_done
);

    localparam int H  = DIV / 2;
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_GAP1  = CW'(H - 1);
    localparam logic [CW-1:0] CNT_S2LO  = CW'(H);
    localparam logic [CW-1:0] CNT_ZERO  = '0;
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        GAP   = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    logic phase_next;
    logic s1_next;
    logic s2_next;
    logic busy_next;
    logic cycle_done_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= CNT_ZERO;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // sync overrides everything; otherwise stopping only ever happens at the
    // cycle boundary so a started strobe is never cut short.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (sync) begin
            state_next = GAP;
            cnt_next   = CNT_ZERO;
        end else begin
            case (state)
                IDLE: begin
                    if (run) begin
                        state_next = RUN;
                        cnt_next   = CNT_ZERO;
                    end
                end
                GAP: begin
                    state_next = run ? RUN : IDLE;
                    cnt_next   = CNT_ZERO;
                end
                RUN: begin
                    if (cnt == CNT_LAST) begin
                        cnt_next = CNT_ZERO;
                        if (!run) begin
                            state_next = IDLE;
                        end
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                        if (!run) begin
                            state_next = DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == CNT_LAST) begin
                        state_next = IDLE;
                        cnt_next   = CNT_ZERO;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                        if (run) begin
                            state_next = RUN;
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = CNT_ZERO;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state and registered, so the strobes
    // come straight off flops and line up with the state they describe.
    always_comb begin
        phase_next      = (state_next == RUN) || (state_next == DRAIN);
        s1_next         = phase_next && (cnt_next < CNT_GAP1);
        s2_next         = phase_next && (cnt_next >= CNT_S2LO) && (cnt_next < CNT_LAST);
        busy_next       = (state_next != IDLE);
        cycle_done_next = phase_next && (cnt_next == CNT_LAST);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1         <= 1'b0;
            s2         <= 1'b0;
            busy       <= 1'b0;
            cycle_done <= 1'b0;
        end else begin
            s1         <= s1_next;
            s2         <= s2_next;
            busy       <= busy_next;
            cycle_done <= cycle_done_next;
        end
    end

    a_non_overlap: assert property (@(posedge clk) disable iff (!reset_n) !(s1 && s2));

    a_done_in_gap: assert property (@(posedge clk) disable iff (!reset_n)
        cycle_done |-> (!s1 && !s2 && busy));

endmodule

// File: tb/tb_tia_phase_gen.sv
// Directed self-checking bench for tia_phase_gen: DIV=4 main instance plus a
// DIV=8 instance for the wider phase pattern.
module tb_tia_phase_gen;

    logic clk;
    logic reset_n;
    logic run;
    logic sync;
    logic s1;
    logic s2;
    logic busy;
    logic cycle_done;

    logic run8;
    logic sync8;
    logic s1_8;
    logic s2_8;
    logic busy8;
    logic cycle_done8;

    int errors;
    int checks;

    tia_phase_gen #(.DIV(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run),
        .sync       (sync),
        .s1         (s1),
        .s2         (s2),
        .busy       (busy),
        .cycle_done (cycle_done)
    );

    tia_phase_gen #(.DIV(8)) dut8 (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (run8),
        .sync       (sync8),
        .s1         (s1_8),
        .s2         (s2_8),
        .busy       (busy8),
        .cycle_done (cycle_done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {s1,s2,busy,cycle_done} per cycle position for DIV=4 and DIV=8.
    logic [3:0] exp4 [4];
    logic [3:0] exp8 [8];

    initial begin
        exp4 = '{4'b1010, 4'b0010, 4'b0110, 4'b0011};
        exp8 = '{4'b1010, 4'b1010, 4'b1010, 4'b0010,
                 4'b0110, 4'b0110, 4'b0110, 4'b0011};
    end

    always @(negedge clk) begin
        if (reset_n) begin
            checks++;
            if ((s1 && s2) || (s1_8 && s2_8)) begin
                errors++;
                $display("[TB] FAIL overlap at %0t: s1=%b s2=%b s1_8=%b s2_8=%b (required never both high)",
                         $time, s1, s2, s1_8, s2_8);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain_to_idle(input string name);
        int n;
        run = 1'b0;
        n = 0;
        while (busy && n < 8) begin
            tick();
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_drain: busy=%b after %0d clocks, required 0", name, busy, n);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        run     = 1'b0;
        sync    = 1'b0;
        run8    = 1'b0;
        sync8   = 1'b0;
        tick();
        tick();
        checks++;
        if ({s1, s2, busy, cycle_done} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %b, required 0000", {s1, s2, busy, cycle_done});
        end
        #2 reset_n = 1'b1;
        tick();
        checks++;
        if ({s1, s2, busy, cycle_done} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_idle: got %b, required 0000", {s1, s2, busy, cycle_done});
        end
    endtask

    task automatic test_run_div4();
        run = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if ({s1, s2, busy, cycle_done} !== exp4[i % 4]) begin
                errors++;
                $display("[TB] FAIL run4_clk%0d: got %b, required %b", i, {s1, s2, busy, cycle_done}, exp4[i % 4]);
            end
        end
        drain_to_idle("run4");
    endtask

    task automatic test_run_div8();
        run8 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            checks++;
            if ({s1_8, s2_8, busy8, cycle_done8} !== exp8[i % 8]) begin
                errors++;
                $display("[TB] FAIL run8_clk%0d: got %b, required %b", i, {s1_8, s2_8, busy8, cycle_done8}, exp8[i % 8]);
            end
        end
        run8 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
        end
        checks++;
        if ({s1_8, s2_8, busy8, cycle_done8} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL run8_stop: got %b, required 0000", {s1_8, s2_8, busy8, cycle_done8});
        end
    endtask

    task automatic test_stop_drain();
        logic [3:0] seq_run  [14];
        logic [3:0] seq_exp  [14];
        // run value driven before each edge, and the outputs required after it
        seq_run = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        seq_exp = '{4'b1010, 4'b0010, 4'b0110, 4'b0011, 4'b0000, 4'b0000,
                    4'b1010, 4'b0010, 4'b0110, 4'b0011, 4'b1010, 4'b0010, 4'b0110, 4'b0011};
        for (int i = 0; i < 14; i++) begin
            run = seq_run[i][0];
            tick();
            checks++;
            if ({s1, s2, busy, cycle_done} !== seq_exp[i]) begin
                errors++;
                $display("[TB] FAIL stop_step%0d: got %b, required %b", i, {s1, s2, busy, cycle_done}, seq_exp[i]);
            end
        end
        run = 1'b0;
        tick();
        checks++;
        if ({s1, s2, busy, cycle_done} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL stop_final_idle: got %b, required 0000", {s1, s2, busy, cycle_done});
        end
    endtask

    task automatic test_sync_pulse();
        logic [1:0] seq_in  [8];
        logic [3:0] seq_exp [8];
        // {run, sync} per edge
        seq_in  = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
        seq_exp = '{4'b1010, 4'b0010, 4'b0110, 4'b0010, 4'b1010, 4'b0010, 4'b0110, 4'b0011};
        for (int i = 0; i < 8; i++) begin
            run  = seq_in[i][1];
            sync = seq_in[i][0];
            tick();
            checks++;
            if ({s1, s2, busy, cycle_done} !== seq_exp[i]) begin
                errors++;
                $display("[TB] FAIL sync_pulse_step%0d: got %b, required %b", i, {s1, s2, busy, cycle_done}, seq_exp[i]);
            end
        end
        sync = 1'b0;
        drain_to_idle("sync_pulse");
    endtask

    task automatic test_sync_hold();
        run = 1'b1;
        tick();
        checks++;
        if ({s1, s2, busy, cycle_done} !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL sync_hold_start: got %b, required 1010", {s1, s2, busy, cycle_done});
        end
        sync = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({s1, s2, busy, cycle_done} !== 4'b0010) begin
                errors++;
                $display("[TB] FAIL sync_hold_gap%0d: got %b, required 0010", i, {s1, s2, busy, cycle_done});
            end
        end
        sync = 1'b0;
        tick();
        checks++;
        if ({s1, s2, busy, cycle_done} !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL sync_hold_restart: got %b, required 1010", {s1, s2, busy, cycle_done});
        end
        drain_to_idle("sync_hold");
        // sync from IDLE with run low: one GAP clock, then back to IDLE
        sync = 1'b1;
        tick();
        checks++;
        if ({s1, s2, busy, cycle_done} !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL sync_idle_gap: got %b, required 0010", {s1, s2, busy, cycle_done});
        end
        sync = 1'b0;
        tick();
        checks++;
        if ({s1, s2, busy, cycle_done} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL sync_idle_return: got %b, required 0000", {s1, s2, busy, cycle_done});
        end
    endtask

    task automatic test_async_reset();
        run = 1'b1;
        tick();
        checks++;
        if ({s1, s2, busy, cycle_done} !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL areset_pre: got %b, required 1010", {s1, s2, busy, cycle_done});
        end
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({s1, s2, busy, cycle_done} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL areset_immediate: got %b, required 0000", {s1, s2, busy, cycle_done});
        end
        tick();
        checks++;
        if ({s1, s2, busy, cycle_done} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL areset_held: got %b, required 0000", {s1, s2, busy, cycle_done});
        end
        #2 reset_n = 1'b1;
        tick();
        checks++;
        if ({s1, s2, busy, cycle_done} !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL areset_restart: got %b, required 1010", {s1, s2, busy, cycle_done});
        end
        tick();
        checks++;
        if ({s1, s2, busy, cycle_done} !== 4'b0010) begin
            errors++;
            $display("[TB] FAIL areset_gap: got %b, required 0010", {s1, s2, busy, cycle_done});
        end
        drain_to_idle("areset");
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        reset_n = 1'b0;
        run     = 1'b0;
        sync    = 1'b0;
        run8    = 1'b0;
        sync8   = 1'b0;
        test_reset();
        test_run_div4();
        test_run_div8();
        test_stop_drain();
        test_sync_pulse();
        test_sync_hold();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
